// File: rtl/dwt_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dwt_sched_pkg
//  Brief    : Shared types and reset constants for the DWT frame scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package dwt_sched_pkg;

    // Scheduler phases: waiting for a capture, launching the engine,
    // engine running, finished frame waiting for display vsync.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } sched_state_t;

    // Frame bank index; only 0, 1 and 2 are ever used.
    typedef logic [1:0] bank_t;

    localparam bank_t CAP_BANK_RST  = 2'd0;
    localparam bank_t DWT_BANK_RST  = 2'd1;
    localparam bank_t DISP_BANK_RST = 2'd2;

endpackage : dwt_sched_pkg
`default_nettype wire

// File: rtl/dwt_sched_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : dwt_sched_watchdog
//  Brief    : RUN-phase cycle counter; flags expiry on the WDOG_CYCLES-th
//             consecutive RUN cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module dwt_sched_watchdog #(
    parameter int WDOG_CYCLES = 1048576
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,     // scheduler is about to enter RUN
    input  logic run,       // scheduler is in RUN this cycle
    output logic expire     // this RUN cycle is the last one allowed
);

    localparam int CNT_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Count RUN cycles; the count restarts each time a new frame launches.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (run && (r_count != C_LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Expiry is seen on the cycle that holds the final permitted count, so the
    // scheduler leaves RUN on the edge ending its WDOG_CYCLES-th cycle.
    assign expire = run && (r_count == C_LAST);

endmodule : dwt_sched_watchdog
`default_nettype wire

// File: rtl/dwt_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : dwt_frame_scheduler
//  Brief    : Triple-buffer bank scheduler between capture, Haar DWT engine
//             and display. Optional RUN watchdog enabled by defining
//             DWT_SCHED_WATCHDOG_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module dwt_frame_scheduler
    import dwt_sched_pkg::*;
#(
    parameter int WDOG_CYCLES = 1048576,
    parameter int DROP_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cap_frame_done,
    input  logic              disp_vsync,
    input  logic [3:0]        levels_in,
    input  logic              dwt_off_switch,
    output logic              dwt_new_frame,
    output logic [3:0]        dwt_levels,
    output bank_t             cap_bank,
    output bank_t             dwt_bank,
    output bank_t             disp_bank,
    output logic              busy,
    output logic [DROP_W-1:0] dropped,
    output logic              wdog_timeout
);

    // The watchdog counter needs at least two cycles to be meaningful.
    if (WDOG_CYCLES < 2) begin : g_wdog_cycles_check
        $error("dwt_frame_scheduler: WDOG_CYCLES must be at least 2");
    end

    sched_state_t      r_state;
    logic              w_wdog_expire;
    logic [DROP_W-1:0] w_dropped_next;

    // Rejected captures count up and stick at all-ones.
    assign w_dropped_next = (dropped == {DROP_W{1'b1}}) ? dropped
                                                        : dropped + DROP_W'(1);

`ifdef DWT_SCHED_WATCHDOG_EN
    logic w_run_entry;
    logic r_wdog_timeout;

    assign w_run_entry = (r_state == START) && (dwt_levels != 4'd0);

    dwt_sched_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_run_entry),
        .run    (r_state == RUN),
        .expire (w_wdog_expire)
    );

    // Sticky timeout flag; only a reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wdog_timeout <= 1'b0;
        end else if (w_wdog_expire) begin
            r_wdog_timeout <= 1'b1;
        end
    end

    assign wdog_timeout = r_wdog_timeout;
`else
    assign w_wdog_expire = 1'b0;
    assign wdog_timeout  = 1'b0;
`endif

    // Bank ownership FSM; every output is updated on the edge that samples
    // its triggering pulse so the engine sees dwt_bank with the launch pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            cap_bank      <= CAP_BANK_RST;
            dwt_bank      <= DWT_BANK_RST;
            disp_bank     <= DISP_BANK_RST;
            dwt_levels    <= 4'd0;
            dwt_new_frame <= 1'b0;
            busy          <= 1'b0;
            dropped       <= '0;
        end else begin
            dwt_new_frame <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Free engine bank: take the fresh capture, hand capture
                    // the old engine bank.
                    if (cap_frame_done) begin
                        cap_bank      <= dwt_bank;
                        dwt_bank      <= cap_bank;
                        dwt_levels    <= levels_in;
                        dwt_new_frame <= 1'b1;
                        busy          <= 1'b1;
                        r_state       <= START;
                    end
                end
                START: begin
                    if (cap_frame_done) begin
                        dropped <= w_dropped_next;
                    end
                    // Zero levels: frame goes to display untouched.
                    if (dwt_levels == 4'd0) begin
                        busy    <= 1'b0;
                        r_state <= HOLD;
                    end else begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (cap_frame_done) begin
                        dropped <= w_dropped_next;
                    end
                    if (dwt_off_switch || w_wdog_expire) begin
                        busy    <= 1'b0;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (disp_vsync && cap_frame_done) begin
                        // Three-way rotation: finished frame to display, new
                        // capture to engine, old display bank to capture.
                        disp_bank     <= dwt_bank;
                        dwt_bank      <= cap_bank;
                        cap_bank      <= disp_bank;
                        dwt_levels    <= levels_in;
                        dwt_new_frame <= 1'b1;
                        busy          <= 1'b1;
                        r_state       <= START;
                    end else if (disp_vsync) begin
                        disp_bank <= dwt_bank;
                        dwt_bank  <= disp_bank;
                        r_state   <= IDLE;
                    end else if (cap_frame_done) begin
                        dropped <= w_dropped_next;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : dwt_frame_scheduler
`default_nettype wire
